// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter. Two requesters (ALU = 0, LSU = 1) share one
// registered write port. A per-register busy scoreboard supports decode hazard checks.
module wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NREG       = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  input  logic [4:0]            req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,

  input  logic                  req1_valid,
  input  logic [4:0]            req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,

  input  logic                  iss_ena,
  input  logic [4:0]            iss_addr,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,

  output logic                  w_ena,
  output logic [4:0]            w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  idle
);

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_e;

  pri_e                  rr;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  grant0;
  logic                  grant1;
  logic                  contended;
  logic                  xfer;
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Grant is combinational; ready is forced low while reset is held.
  assign contended = req0_valid && req1_valid;
  assign grant0    = !rst && req0_valid && (!req1_valid || (rr == PRI_ALU));
  assign grant1    = !rst && req1_valid && (!req0_valid || (rr == PRI_LSU));
  assign xfer      = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_addr = grant1 ? req1_addr : req0_addr;
  assign sel_data = grant1 ? req1_data : req0_data;

  // NOTE: always_comb uses blocking '=' with a default first, so no latch is
  // inferred; the clocked block below uses '<=' only.
  always_comb begin
    busy_nxt = busy;
    if (w_ena) busy_nxt[w_addr] = 1'b0;
    // Set is applied after clear so a same-edge reissue keeps the bit busy.
    if (iss_ena && (iss_addr != 5'd0)) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the scoreboard is reset explicitly; a stale busy bit after reset
  // would stall decode forever, so it cannot be left as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr     <= PRI_ALU;
      w_ena  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      busy   <= '0;
    end else begin
      if (contended) rr <= grant0 ? PRI_LSU : PRI_ALU;
      w_ena <= xfer && (sel_addr != 5'd0);
      if (xfer) begin
        w_addr <= sel_addr;
        w_data <= sel_data;
      end
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = (rs1_addr != 5'd0) && busy[rs1_addr];
  assign rs2_busy = (rs2_addr != 5'd0) && busy[rs2_addr];
  assign idle     = (busy == '0) && !w_ena;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Controller for the integer register-file write port.
- Arbitrates between two write-back requesters: requester 0 is the ALU/execute path, requester 1 is the load/LSU path. Each cycle it forwards at most one write through a registered stage to the regfile write port (w_ena/w_addr/w_data).
- Keeps a per-register busy scoreboard. Decode sets a bit when it issues an instruction with a destination; the arbiter clears the bit when the matching write commits. Decode queries the scoreboard for rs1/rs2 hazards.

Parameters:
- DATA_WIDTH, 64, width of register data.
- NREG, 32, number of architectural registers; the address width is 5 bits and fixed.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- req0_valid, input, 1, requester 0 (ALU) has a write pending.
- req0_addr, input, 5, requester 0 destination register.
- req0_data, input, DATA_WIDTH, requester 0 write data.
- req0_ready, output, 1, requester 0 is granted this cycle.
- req1_valid, input, 1, requester 1 (LSU) has a write pending.
- req1_addr, input, 5, requester 1 destination register.
- req1_data, input, DATA_WIDTH, requester 1 write data.
- req1_ready, output, 1, requester 1 is granted this cycle.
- iss_ena, input, 1, decode issues an instruction that writes iss_addr.
- iss_addr, input, 5, destination register of the issuing instruction.
- rs1_addr, input, 5, decode source-1 query address.
- rs2_addr, input, 5, decode source-2 query address.
- rs1_busy, output, 1, rs1_addr has an uncommitted write.
- rs2_busy, output, 1, rs2_addr has an uncommitted write.
- w_ena, output, 1, regfile write enable (registered).
- w_addr, output, 5, regfile write address (registered).
- w_data, output, DATA_WIDTH, regfile write data (registered).
- idle, output, 1, no busy bits set and w_ena low.

Behaviour:
- Reset (async, while rst=1):
  - w_ena=0, w_addr=0, w_data=0.
  - All busy bits cleared; rr pointer = requester 0.
  - req0_ready=req1_ready=0; rs1_busy=rs2_busy=0; idle=1.
  - A write pending in the output stage is dropped.
- Handshake: valid/ready. A transfer occurs when valid&&ready are both high at the rising edge. A requester holds valid/addr/data stable until accepted; the arbiter never depends on valid dropping.
- Arbitration (combinational grant):
  - One valid: that requester gets ready=1.
  - Both valid: the requester selected by rr gets ready; the other gets ready=0.
  - Neither valid: both ready=0.
  - ready is never asserted without valid.
- rr pointer: after a contended grant (both valid), rr points at the loser. An uncontended grant leaves rr unchanged. Starvation bound: a waiting requester is granted within 2 cycles.
- Output stage (1-cycle latency), on the edge of the accepted transfer:
  - w_ena <= (addr != 0); w_addr <= addr; w_data <= data.
  - A write to x0 completes the handshake but produces w_ena=0.
  - No transfer: w_ena <= 0; w_addr/w_data hold their previous values.
- Scoreboard: busy[31:1]; x0 is never busy.
  - Set: iss_ena=1 with iss_addr!=0 sets busy[iss_addr] on the edge.
  - Clear: w_ena=1 clears busy[w_addr] on the edge. This is the same edge on which the regfile latches the write, so busy=0 implies the regfile holds the value.
  - Same register set and cleared on one edge: set wins (the new producer is outstanding).
  - Clear of a non-busy register: no effect, no error.
  - iss_ena to an already-busy register: the bit stays set. Ordering (WAW) is decode's responsibility; the first commit clears the bit.
- Queries: rs1_busy = (rs1_addr!=0) && busy[rs1_addr], and likewise for rs2. Purely combinational from the current state; there is no bypass of same-cycle iss_ena or same-cycle commit.
- idle = (busy==0) && !w_ena.

Test Plan:
- Reset mid-write: req0 accepted with addr=5, data=0x11, then rst asserted before the next edge -> w_ena=0 immediately, busy[5]=0, ready=0 while rst=1.
- Single write: iss_ena, addr=3 at cycle 0; req0 at cycle 2 with data=0xDEAD -> req0_ready=1 at cycle 2; at cycle 3 w_ena=1, w_addr=3, w_data=0xDEAD and rs1_busy(3)=1; at cycle 4 rs1_busy(3)=0, idle=1.
- Contention fairness: req0 and req1 valid continuously for 6 cycles from reset -> grants go 0,1,0,1,0,1; each w_* write appears one cycle after its grant.
- x0 write: req1 addr=0, data=0xFF -> req1_ready=1, next cycle w_ena=0; busy unchanged; rs1_busy(0)=0 even after iss_ena with addr=0.
- Set/clear collision: busy[7] set; an issue to register 7 on the same edge its commit has w_ena=1, w_addr=7 -> busy[7] remains 1; a second write to 7 later clears it.
- Hold-until-accept: req1 valid, addr=9, data=0x42 while losing to req0 for 1 cycle -> granted the next cycle; exactly one w_ena pulse each for regs 9 and req0's address, with no duplicates.
